light_round_ctrl: RTL and testbench
===================================

Name: light_round_ctrl

Overview:
- Sequences the 3-bit light-sweep counter (idle position 5, sweeps 0..4, returns to 5) for a two-player reaction game.
- Arbitrates round-robin between two players requesting a sweep, launches the sweep via its start/speed inputs and watches its position output.
- Scores the owning player's button press against a target position and escalates that player's speed on each hit.
- Sits between the debounced player buttons and the light counter. Drives score and status outputs to the display logic.

Parameters:
TARGET, 4, sweep position at which a press counts as a hit (0..4)
SCORE_W, 4, width of each score register
WIN_SCORE, 9, score value that ends the game
LAUNCH_TO, 63, max cycles in LAUNCH waiting for pos to leave 5 before abort

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
req  in  2  per-player round request, level; bit i = player i
btn  in  2  per-player press, one-cycle pulse (already debounced)
pos  in  3  light counter position (5 = idle)
start  out  1  start to light counter
speed  out  2  speed select to light counter
grant  out  2  one-hot round owner, 0 when no round
score0  out  SCORE_W  player 0 score
score1  out  SCORE_W  player 1 score
fault  out  1  one-cycle pulse on launch timeout
done  out  1  game over, sticky until Reset
winner  out  1  valid when done; index of winning player

Behaviour:
- Reset:
  - state=IDLE; start=0, grant=0, fault=0, done=0, winner=0.
  - score0=score1=0; per-player speed regs spd0=spd1=0; rr pointer=0 (player 0 favoured first).
- speed output = spd of granted player; spd0 when grant=0.
- FSM states: IDLE, LAUNCH, RUN, SCORE, OVER.
- IDLE, when done=0 and req!=0:
  - grant the requester. If both request, grant the player at the rr pointer.
  - grant is registered: visible the cycle after req is sampled. Go to LAUNCH.
- LAUNCH:
  - start=1 every cycle.
  - Clear hit/early flags on entry.
  - When pos!=5 is sampled: start=0 next cycle, go to RUN.
  - If LAUNCH_TO cycles elapse with pos==5: pulse fault for 1 cycle, grant=0, go to IDLE. Score and rr pointer unchanged.
- RUN:
  - Only btn[owner] is examined; the other player's btn is ignored. Only the first owner press of the round is evaluated; later presses are ignored.
  - Press with pos==TARGET sets hit. Press with pos<TARGET sets early.
  - When pos==5 is sampled, go to SCORE.
- SCORE (one cycle):
  - On hit: owner score +1, saturating at 2^SCORE_W-1; owner spd +1, saturating at 3.
  - On no hit: owner spd reset to 0.
  - rr pointer = other player; grant=0.
  - If updated score >= WIN_SCORE: done=1, winner=owner, go to OVER. Otherwise go to IDLE.
- OVER: all req/btn ignored, outputs frozen until Reset.
- Round latency: a round can begin no sooner than 1 cycle after SCORE. A held req from the same player is re-granted only if the other player is not requesting.
- Reset mid-round: immediate return to reset values; start drops the cycle after Reset is sampled.
- Simultaneous btn and pos→5 transition in the same cycle: the press is evaluated against the sampled pos (5), so it is neither hit nor early.

Optional Feature:
- Macro LRC_EARLY_PENALTY_EN.
- Defined: an early press in RUN decrements the owner score in SCORE, saturating at 0; spd is reset to 0 as for a miss.
- Undefined: the early flag is unused, and an early press only consumes the round's single press (no hit possible afterwards).

Test Plan:
1. Reset, req=01, hold pos=5 two cycles, then pos 0..4,5 with btn[0] pulse at pos=4 -> grant=01 cycle after req, start high until pos=0, score0=1, spd0=1, grant=00 after SCORE.
2. req=11 from reset -> grant=01 first. After its round, req still 11 -> grant=10. After that round -> grant=01.
3. Owner 0 round, btn[1] pulses at pos=4, btn[0] never pressed -> score0=0, score1=0, spd0 returns to 0 from a preset 2.
4. req=01, pos held at 5 for 63 cycles -> fault one-cycle pulse, grant=00, start=0, scores unchanged; next req=01 relaunches.
5. Player 0 hits 9 consecutive rounds -> spd0 saturates at 3 from round 3, done=1, winner=0 after ninth SCORE. Further req/btn give no change until Reset clears everything.
6. btn[0] at pos=2, then at pos=4 in the same round -> no hit. Score0 drops from 3 to 2 with LRC_EARLY_PENALTY_EN defined, stays 3 without it.

Source files
------------

// File: rtl/light_round_ctrl.sv
// -----------------------------------------------------------------------------
// light_round_ctrl
//   Round controller for a two-player light-sweep reaction game. Arbitrates
//   round-robin between player round requests, launches the light counter,
//   watches the sweep position, scores the owning player's first press and
//   escalates that player's sweep speed on every hit.
//
// Ports
//   Clock   : system clock
//   Reset   : synchronous, active-high reset
//   req     : per-player round request (level), bit i = player i
//   btn     : per-player debounced press, one-cycle pulse
//   pos     : light counter position, 5 = idle, 0..4 = sweep
//   start   : start request to the light counter (high through launch)
//   speed   : speed select of the granted player (player 0 when no round)
//   grant   : one-hot round owner, 0 when no round
//   score0  : player 0 score
//   score1  : player 1 score
//   fault   : one-cycle pulse when the light counter never left idle
//   done    : game over, sticky until Reset
//   winner  : index of the winning player, valid while done
//
// Build option
//   LRC_EARLY_PENALTY_EN : when defined, a press before the target position
//                          costs the owner one point (saturating at 0).
// -----------------------------------------------------------------------------
module light_round_ctrl #(
  parameter int unsigned TARGET    = 4,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned WIN_SCORE = 9,
  parameter int unsigned LAUNCH_TO = 63
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         req,
  input  logic [1:0]         btn,
  input  logic [2:0]         pos,
  output logic               start,
  output logic [1:0]         speed,
  output logic [1:0]         grant,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               fault,
  output logic               done,
  output logic               winner
);

  localparam int unsigned CNT_W = (LAUNCH_TO < 2) ? 1 : $clog2(LAUNCH_TO);
  localparam logic [2:0]         POS_IDLE  = 3'd5;
  localparam logic [2:0]         POS_TGT   = 3'(TARGET);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(LAUNCH_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_SCORE  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t             state, state_n;
  logic               start_n, fault_n, done_n, winner_n;
  logic [1:0]         grant_n;
  logic [SCORE_W-1:0] score0_n, score1_n;
  logic [1:0]         spd0, spd1, spd0_n, spd1_n;
  logic               rr, rr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               pressed, pressed_n;
  logic               hit, hit_n;
`ifdef LRC_EARLY_PENALTY_EN
  logic               early, early_n;
`endif

  // Round owner and its per-player state, selected by the one-hot grant
  logic               owner;
  logic               own_btn;
  logic [SCORE_W-1:0] own_score;
  logic [1:0]         own_spd;
  logic [SCORE_W-1:0] upd_score;
  logic [1:0]         upd_spd;

  assign owner     = grant[1];
  assign own_btn   = owner ? btn[1]  : btn[0];
  assign own_score = owner ? score1  : score0;
  assign own_spd   = owner ? spd1    : spd0;

  // Speed follows the owner; player 0's setting is shown between rounds
  assign speed = grant[1] ? spd1 : spd0;

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    start_n   = start;
    grant_n   = grant;
    fault_n   = 1'b0;
    done_n    = done;
    winner_n  = winner;
    score0_n  = score0;
    score1_n  = score1;
    spd0_n    = spd0;
    spd1_n    = spd1;
    rr_n      = rr;
    cnt_n     = cnt;
    pressed_n = pressed;
    hit_n     = hit;
`ifdef LRC_EARLY_PENALTY_EN
    early_n   = early;
`endif
    upd_score = own_score;
    upd_spd   = own_spd;

    case (state)
      S_IDLE: begin
        if (!done && (req != 2'b00)) begin
          // Contention goes to the rr pointer; a lone requester always wins
          if (req == 2'b11) begin
            grant_n = rr ? 2'b10 : 2'b01;
          end else begin
            grant_n = req;
          end
          start_n   = 1'b1;
          cnt_n     = '0;
          pressed_n = 1'b0;
          hit_n     = 1'b0;
`ifdef LRC_EARLY_PENALTY_EN
          early_n   = 1'b0;
`endif
          state_n   = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (pos != POS_IDLE) begin
          start_n = 1'b0;
          state_n = S_RUN;
        end else if (cnt == CNT_LAST) begin
          // Light counter never responded: abandon the round untouched
          fault_n = 1'b1;
          grant_n = 2'b00;
          start_n = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_RUN: begin
        // Only the owner's first press of the round counts
        if (own_btn && !pressed) begin
          pressed_n = 1'b1;
          if (pos == POS_TGT) begin
            hit_n = 1'b1;
          end
`ifdef LRC_EARLY_PENALTY_EN
          else if (pos < POS_TGT) begin
            early_n = 1'b1;
          end
`endif
        end
        if (pos == POS_IDLE) begin
          state_n = S_SCORE;
        end
      end

      S_SCORE: begin
        if (hit) begin
          upd_score = (own_score == SCORE_MAX) ? own_score : own_score + SCORE_W'(1);
          upd_spd   = (own_spd == 2'd3) ? 2'd3 : own_spd + 2'd1;
        end else begin
          upd_spd = 2'd0;
`ifdef LRC_EARLY_PENALTY_EN
          if (early && (own_score != '0)) begin
            upd_score = own_score - SCORE_W'(1);
          end
`endif
        end

        if (owner) begin
          score1_n = upd_score;
          spd1_n   = upd_spd;
        end else begin
          score0_n = upd_score;
          spd0_n   = upd_spd;
        end

        rr_n    = ~owner;
        grant_n = 2'b00;

        if (upd_score >= SCORE_WIN) begin
          done_n   = 1'b1;
          winner_n = owner;
          state_n  = S_OVER;
        end else begin
          state_n  = S_IDLE;
        end
      end

      S_OVER: begin
        state_n = S_OVER;
      end

      default: begin
        state_n = S_IDLE;
        start_n = 1'b0;
        grant_n = 2'b00;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      start   <= 1'b0;
      grant   <= 2'b00;
      fault   <= 1'b0;
      done    <= 1'b0;
      winner  <= 1'b0;
      score0  <= '0;
      score1  <= '0;
      spd0    <= 2'd0;
      spd1    <= 2'd0;
      rr      <= 1'b0;
      cnt     <= '0;
      pressed <= 1'b0;
      hit     <= 1'b0;
`ifdef LRC_EARLY_PENALTY_EN
      early   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      start   <= start_n;
      grant   <= grant_n;
      fault   <= fault_n;
      done    <= done_n;
      winner  <= winner_n;
      score0  <= score0_n;
      score1  <= score1_n;
      spd0    <= spd0_n;
      spd1    <= spd1_n;
      rr      <= rr_n;
      cnt     <= cnt_n;
      pressed <= pressed_n;
      hit     <= hit_n;
`ifdef LRC_EARLY_PENALTY_EN
      early   <= early_n;
`endif
    end
  end

endmodule

// File: tb/tb_light_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_light_round_ctrl
//   Scoreboard bench for light_round_ctrl. The driver plays the light counter
//   and the players; for each round it predicts the grant/speed at round start
//   and the score/status at round end from the game rules and queues them.
//   A monitor pops and compares whenever grant rises or falls.
// -----------------------------------------------------------------------------
module tb_light_round_ctrl;

  localparam int unsigned TARGET    = 4;
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned WIN_SCORE = 9;
  localparam int unsigned LAUNCH_TO = 63;
  localparam int          SMAX      = (1 << SCORE_W) - 1;

  logic               Clock;
  logic               Reset;
  logic [1:0]         req;
  logic [1:0]         btn;
  logic [2:0]         pos;
  logic               start;
  logic [1:0]         speed;
  logic [1:0]         grant;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic               fault;
  logic               done;
  logic               winner;

  light_round_ctrl #(
    .TARGET(TARGET), .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .LAUNCH_TO(LAUNCH_TO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .btn(btn), .pos(pos),
    .start(start), .speed(speed), .grant(grant), .score0(score0), .score1(score1),
    .fault(fault), .done(done), .winner(winner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  typedef struct { int g; int spd; } gexp_t;
  typedef struct { int f; int s0; int s1; int d; int w; } eexp_t;
  gexp_t gq[$];
  eexp_t eq[$];

  // Reference game state
  int m_score[2];
  int m_spd[2];
  int m_rr, m_done, m_winner;
  int exp_faults, seen_faults;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score[0] = 0; m_score[1] = 0;
    m_spd[0]   = 0; m_spd[1]   = 0;
    m_rr = 0; m_done = 0; m_winner = 0;
  endtask

  function automatic int pick_owner(input logic [1:0] r);
    if (r == 2'b11) return m_rr;
    return r[1] ? 1 : 0;
  endfunction

  // Apply the round outcome for owner o whose first press was at position fp
  task automatic model_end(input int o, input int fp);
    bit hit, early;
    hit   = (fp == int'(TARGET));
    early = (fp >= 0) && (fp < int'(TARGET));
    if (hit) begin
      m_score[o] = (m_score[o] < SMAX) ? m_score[o] + 1 : SMAX;
      m_spd[o]   = (m_spd[o] < 3) ? m_spd[o] + 1 : 3;
    end else begin
      m_spd[o] = 0;
`ifdef LRC_EARLY_PENALTY_EN
      if (early && m_score[o] > 0) m_score[o] = m_score[o] - 1;
`else
      if (early) m_spd[o] = 0;
`endif
    end
    m_rr = 1 - o;
    if (m_score[o] >= int'(WIN_SCORE)) begin
      m_done = 1;
      m_winner = o;
    end
  endtask

  function automatic eexp_t cur_end(input int f);
    eexp_t e;
    e.f = f; e.s0 = m_score[0]; e.s1 = m_score[1]; e.d = m_done; e.w = m_winner;
    return e;
  endfunction

  // Monitor: compare at every grant rise (round start) and fall (round end)
  logic [1:0] prev_g = 2'b00;
  gexp_t ge;
  eexp_t ee;
  always @(negedge Clock) begin
    if (fault) seen_faults++;
    if (prev_g == 2'b00 && grant != 2'b00) begin
      if (gq.size() == 0) begin
        chk("grant_unexpected", int'(grant), 0);
      end else begin
        ge = gq.pop_front();
        chk("grant", int'(grant), ge.g);
        chk("speed", int'(speed), ge.spd);
        chk("start_on_grant", int'(start), 1);
      end
    end
    if (prev_g != 2'b00 && grant == 2'b00) begin
      if (eq.size() == 0) begin
        chk("end_unexpected", 1, 0);
      end else begin
        ee = eq.pop_front();
        chk("end_fault", int'(fault), ee.f);
        chk("end_score0", int'(score0), ee.s0);
        chk("end_score1", int'(score1), ee.s1);
        chk("end_done", int'(done), ee.d);
        chk("end_winner", int'(winner), ee.w);
        chk("end_start", int'(start), 0);
      end
    end
    prev_g = grant;
  end

  task automatic apply_reset();
    Reset = 1'b1; req = 2'b00; btn = 2'b00; pos = 3'd5;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    chk("rst_start", int'(start), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_score0", int'(score0), 0);
    chk("rst_score1", int'(score1), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_speed", int'(speed), 0);
  endtask

  // One round: d idle cycles before the sweep (d >= LAUNCH_TO forces a
  // timeout); owner presses at positions p1/p2 (-1 = none); optional
  // press by the other player at the target.
  task automatic do_round(input logic [1:0] r, input int d, input int p1,
                          input int p2, input bit noise);
    int seq[7] = '{0, 0, 1, 2, 3, 4, 5};
    int o, n, fp, idx;
    bit to;
    to = (d >= int'(LAUNCH_TO));
    o  = pick_owner(r);
    gq.push_back('{g: (o == 1) ? 2 : 1, spd: m_spd[o]});
    if (to) begin
      exp_faults++;
      eq.push_back(cur_end(1));
    end else begin
      fp = -1;
      if (p1 >= 0 && p1 <= 5) fp = p1;
      if (p2 >= 0 && p2 <= 5 && (fp < 0 || p2 < fp)) fp = p2;
      model_end(o, fp);
      eq.push_back(cur_end(0));
    end

    req = r;
    n = 0;
    do begin @(negedge Clock); n++; end while (grant == 2'b00 && n < 8);
    chk("grant_latency", n, 1);
    req = 2'b00;

    if (to) begin
      pos = 3'd5;
      n = 0;
      while (grant != 2'b00 && n < int'(LAUNCH_TO) + 8) begin @(negedge Clock); n++; end
      chk("timeout_cycles", n, int'(LAUNCH_TO));
      chk("timeout_start", int'(start), 0);
      return;
    end

    pos = 3'd5;
    repeat (d) @(negedge Clock);
    chk("start_in_launch", int'(start), 1);
    for (int s = 0; s < 7; s++) begin
      pos = 3'(seq[s]);
      btn = 2'b00;
      if (s >= 1) begin
        idx = seq[s];
        if (idx == p1 || idx == p2) btn[o] = 1'b1;
        if (noise && idx == int'(TARGET)) btn[1-o] = 1'b1;
      end
      @(negedge Clock);
      if (s == 0) chk("start_dropped", int'(start), 0);
    end
    btn = 2'b00;
    pos = 3'd5;
    n = 0;
    while (grant != 2'b00 && n < 4) begin @(negedge Clock); n++; end
    chk("round_end_grant", int'(grant), 0);
  endtask

  // Game over: everything must stay frozen regardless of inputs
  task automatic over_phase();
    repeat (10) begin
      req = 2'($urandom);
      btn = 2'($urandom);
      pos = 3'($urandom_range(0, 5));
      @(negedge Clock);
      chk("over_grant", int'(grant), 0);
      chk("over_start", int'(start), 0);
      chk("over_done", int'(done), 1);
      chk("over_winner", int'(winner), m_winner);
      chk("over_score0", int'(score0), m_score[0]);
      chk("over_score1", int'(score1), m_score[1]);
    end
    req = 2'b00; btn = 2'b00; pos = 3'd5;
  endtask

  task automatic midround_reset();
    int n;
    gq.push_back('{g: 1, spd: m_spd[0]});
    eq.push_back('{f: 0, s0: 0, s1: 0, d: 0, w: 0});
    req = 2'b01;
    n = 0;
    do begin @(negedge Clock); n++; end while (grant == 2'b00 && n < 8);
    req = 2'b00;
    pos = 3'd5; @(negedge Clock);
    pos = 3'd0; @(negedge Clock);
    pos = 3'd1; Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_start", int'(start), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_score0", int'(score0), 0);
    Reset = 1'b0; pos = 3'd5;
    model_reset();
    @(negedge Clock);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, d, p1, p2;
    exp_faults = 0; seen_faults = 0;
    Reset = 1'b1; req = 2'b00; btn = 2'b00; pos = 3'd5;
    model_reset();
    @(negedge Clock);
    apply_reset();

    // Basic hit from reset
    do_round(2'b01, 2, int'(TARGET), -1, 1'b0);

    // Round-robin under constant contention
    apply_reset();
    do_round(2'b11, 0, int'(TARGET), -1, 1'b0);
    do_round(2'b11, 1, -1, -1, 1'b0);
    do_round(2'b11, 0, int'(TARGET), -1, 1'b0);

    // Other player's press ignored; owner miss clears a raised speed
    apply_reset();
    do_round(2'b01, 0, int'(TARGET), -1, 1'b0);
    do_round(2'b01, 0, int'(TARGET), -1, 1'b0);
    do_round(2'b01, 1, -1, -1, 1'b1);
    do_round(2'b01, 0, -1, -1, 1'b0);

    // Launch timeout, then the longest legal launch wait
    do_round(2'b01, int'(LAUNCH_TO), -1, -1, 1'b0);
    do_round(2'b01, int'(LAUNCH_TO) - 1, int'(TARGET), -1, 1'b0);

    // Early press consumes the round; press coinciding with return to idle
    apply_reset();
    repeat (3) do_round(2'b01, 0, int'(TARGET), -1, 1'b0);
    do_round(2'b01, 0, 2, int'(TARGET), 1'b0);
    do_round(2'b01, 0, 5, -1, 1'b0);

    midround_reset();

    // Winning streak with speed saturation, then frozen game
    apply_reset();
    repeat (WIN_SCORE) do_round(2'b01, 0, int'(TARGET), -1, 1'b0);
    chk("win_done", int'(done), 1);
    chk("win_winner", int'(winner), 0);
    over_phase();
    apply_reset();

    // Randomized rounds
    for (int i = 0; i < 80; i++) begin
      if (m_done != 0) begin
        over_phase();
        apply_reset();
      end
      r  = $urandom_range(1, 3);
      d  = ($urandom_range(0, 11) == 0) ? int'(LAUNCH_TO) : $urandom_range(0, 4);
      p1 = ($urandom_range(0, 1) == 1) ? int'(TARGET) : $urandom_range(0, 6) - 1;
      p2 = $urandom_range(0, 6) - 1;
      do_round(2'(r), d, p1, p2, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge Clock);
    chk("grant_queue_drained", gq.size(), 0);
    chk("end_queue_drained", eq.size(), 0);
    chk("fault_pulse_cycles", seen_faults, exp_faults);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
